// File: rtl/mips32i_dmem_responder.sv
// mips32i_dmem_responder
//   Data-memory responder for the CPU load/store port. Backs the port with a
//   2**ADDR_W x 32-bit array, supports byte/half/word loads and stores with
//   big-endian lane steering, sign/zero extension on narrow loads, and a
//   one-cycle registered response. Misaligned or illegal-size accesses are
//   flagged with rsp_err and never write the array.
//
// Parameters
//   ADDR_W        word-address width; byte address bits [ADDR_W+1:2] index the array
//
// Ports
//   clk           clock, all logic on posedge
//   rst           synchronous active-low reset
//   req_valid     request present
//   req_ready     responder can accept (transfer = req_valid & req_ready)
//   req_we        1 = store, 0 = load
//   req_size      00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  loads only: 1 = zero-extend, 0 = sign-extend
//   req_addr      byte address (bits above ADDR_W+1 ignored)
//   req_wdata     store data, right-aligned
//   rsp_valid     response valid, one cycle after accept
//   rsp_rdata     extended load data; 0 for stores and errors
//   rsp_err       misaligned or illegal-size access
//
// Build option
//   DMEM_INIT_CLEAR_EN  when defined, every reset is followed by a sweep that
//                       writes zero to all words before requests are accepted.
module mips32i_dmem_responder #(
  parameter int unsigned ADDR_W = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

`ifdef DMEM_INIT_CLEAR_EN
  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;
  localparam state_t RESET_STATE = ST_CLEAR;
`else
  typedef enum logic {ST_RUN = 1'b1} state_t;
  localparam state_t RESET_STATE = ST_RUN;
`endif

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_clr_we;
  logic [ADDR_W-1:0]   r_clr_cnt;

  logic [31:0]         r_mem [DEPTH];
  logic [31:0]         r_rword;
  logic                r_valid;
  logic                r_err;
  logic                r_load;
  logic [1:0]          r_size;
  logic [1:0]          r_lane;
  logic                r_uns;

  logic                w_fire;
  logic                w_err;
  logic                w_store;
  logic [ADDR_W-1:0]   w_idx;
  logic [3:0]          w_be;
  logic [31:0]         w_wlanes;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic                w_unused_addr;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst) r_state <= RESET_STATE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    w_clr_we    = 1'b0;
    case (r_state)
`ifdef DMEM_INIT_CLEAR_EN
      ST_CLEAR: begin
        w_clr_we = rst;
        if (r_clr_cnt == '1) w_state_nxt = ST_RUN;
      end
`endif
      ST_RUN:   req_ready = rst;
      default:  w_state_nxt = RESET_STATE;
    endcase
  end

`ifdef DMEM_INIT_CLEAR_EN
  always_ff @(posedge clk) begin
    if (!rst)          r_clr_cnt <= '0;
    else if (w_clr_we) r_clr_cnt <= r_clr_cnt + 1'b1;
  end
`else
  assign r_clr_cnt = '0;
`endif

  // ---------------- request decode ----------------
  assign w_fire  = req_valid & req_ready;
  assign w_err   = (req_size == 2'b11)
                 | ((req_size == 2'b01) & req_addr[0])
                 | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
  assign w_store = w_fire & req_we & ~w_err;
  assign w_idx   = req_addr[ADDR_W+1:2];
  assign w_unused_addr = ^req_addr[31:ADDR_W+2];

  // Big-endian lanes: byte offset 0 is bits [31:24]. Store data is replicated
  // across lanes so the byte enables alone pick the destination.
  always_comb begin
    w_be     = '0;
    w_wlanes = '0;
    case (req_size)
      2'b00: begin
        w_be     = 4'b1000 >> req_addr[1:0];
        w_wlanes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_be     = req_addr[1] ? 4'b0011 : 4'b1100;
        w_wlanes = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        w_be     = '1;
        w_wlanes = req_wdata;
      end
      default: ;
    endcase
  end

  // ---------------- storage ----------------
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_store) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
      end
    end
    if (w_fire) r_rword <= r_mem[w_idx];
  end

  // ---------------- response ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_load  <= 1'b0;
      r_size  <= '0;
      r_lane  <= '0;
      r_uns   <= 1'b0;
    end else begin
      r_valid <= w_fire;
      r_err   <= w_fire & w_err;
      r_load  <= w_fire & ~req_we & ~w_err;
      r_size  <= req_size;
      r_lane  <= req_addr[1:0];
      r_uns   <= req_unsigned;
    end
  end

  always_comb begin
    case (r_lane)
      2'd0:    w_byte = r_rword[31:24];
      2'd1:    w_byte = r_rword[23:16];
      2'd2:    w_byte = r_rword[15:8];
      default: w_byte = r_rword[7:0];
    endcase
    w_half    = r_lane[1] ? r_rword[15:0] : r_rword[31:16];
    rsp_rdata = '0;
    if (r_load) begin
      case (r_size)
        2'b00:   rsp_rdata = r_uns ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
        2'b01:   rsp_rdata = r_uns ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
        default: rsp_rdata = r_rword;
      endcase
    end
  end

  assign rsp_valid = r_valid;
  assign rsp_err   = r_err;

endmodule
